// File: rtl/mv_display_pkg.sv
// Shared types and glyph table for the mat_vec_mult result display.
// Build option: RESULT_HEX_EN selects hex digits instead of decimal tens/ones.
package mv_display_pkg;

  localparam int COUNT_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    TENS,
    ONES,
    BLANK
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } digits_t;

  function automatic digits_t split_digits(input logic [5:0] r);
    digits_t    d;
    logic [5:0] q;
    logic [5:0] m;
`ifdef RESULT_HEX_EN
    q = {4'd0, r[5:4]};
    m = {2'd0, r[3:0]};
`else
    q = r / 6'd10;
    m = r % 6'd10;
`endif
    d.hi = q[3:0];
    d.lo = m[3:0];
    return d;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational 4-bit digit to active-high 7-segment glyph (bit0=a .. bit6=g).
// Build option: RESULT_HEX_EN (glyphs A..F only reachable in that build).
module seg7_encoder
  import mv_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/mv_result_display.sv
// Shows a 6-bit mat_vec_mult result as tens, ones, blank on one 7-seg digit.
// Build option: RESULT_HEX_EN shows result[5:4] and result[3:0] as hex.
module mv_result_display
  import mv_display_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] result_i,
  input  logic       result_valid_i,
  output logic       result_ready_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       busy_o
);

  localparam logic [COUNT_W-1:0] LAST = MAX_COUNT - 1'b1;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [3:0]         hi_q, hi_d;
  logic [3:0]         lo_q, lo_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               term;
  logic [3:0]         digit_sel;
  logic [6:0]         glyph;
  digits_t            cap;

  assign accept = result_valid_i & ready_q;
  assign term   = (count_q == LAST);
  assign cap    = split_digits(result_i);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      state_d = TENS;
      count_d = '0;
      hi_d    = cap.hi;
      lo_d    = cap.lo;
    end else begin
      unique case (state_q)
        IDLE: count_d = '0;
        TENS: begin
          state_d = term ? ONES : TENS;
          count_d = term ? '0 : count_q + 1'b1;
        end
        ONES: begin
          state_d = term ? BLANK : ONES;
          count_d = term ? '0 : count_q + 1'b1;
        end
        BLANK: begin
          state_d = term ? TENS : BLANK;
          count_d = term ? '0 : count_q + 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the glyph lands with it.
  assign digit_sel = (state_d == ONES) ? lo_d : hi_d;

  seg7_encoder u_enc (
    .digit_i (digit_sel),
    .seg_o   (glyph)
  );

  always_comb begin
    seg_d   = SEG_BLANK;
    dp_d    = 1'b0;
    ready_d = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (1'b1)
      (state_d == TENS): begin
        seg_d = glyph;
        dp_d  = 1'b1;
      end
      (state_d == ONES):  seg_d   = glyph;
      (state_d == BLANK): ready_d = 1'b1;
      (state_d == IDLE):  ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign seg_o          = seg_q;
  assign dp_o           = dp_q;
  assign result_ready_o = ready_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_mv_result_display.sv
// Directed bench for mv_result_display with MAX_COUNT=4.
// Expected glyphs follow the RESULT_HEX_EN build option.
module tb_mv_result_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] result_i = '0;
  logic       result_valid_i = 1'b0;
  logic       result_ready_o;
  logic [6:0] seg_o;
  logic       dp_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

`ifdef RESULT_HEX_EN
  localparam logic [6:0] E42_T = 7'h5B;
  localparam logic [6:0] E42_O = 7'h77;
  localparam logic [6:0] E63_T = 7'h4F;
  localparam logic [6:0] E63_O = 7'h71;
  localparam logic [6:0] E17_O = 7'h06;
`else
  localparam logic [6:0] E42_T = 7'h66;
  localparam logic [6:0] E42_O = 7'h5B;
  localparam logic [6:0] E63_T = 7'h7D;
  localparam logic [6:0] E63_O = 7'h4F;
  localparam logic [6:0] E17_O = 7'h07;
`endif

  mv_result_display #(.MAX_COUNT(24'd4)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .seg_o          (seg_o),
    .dp_o           (dp_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    result_valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seg_o !== 7'h00 || dp_o !== 1'b0 ||
          result_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d seg=%h dp=%b rdy=%b busy=%b want 00 0 1 0",
                 i, seg_o, dp_o, result_ready_o, busy_o);
      end
      step();
    end
  endtask

  task automatic test_value(input logic [5:0] r, input logic [6:0] et,
                            input logic [6:0] eo, input string nm);
    logic [6:0] es;
    logic       ed;
    logic       er;
    do_reset();
    result_i = r;
    result_valid_i = 1'b1;
    step();
    result_valid_i = 1'b0;
    for (int i = 0; i < 13; i++) begin
      es = (i < 4 || i == 12) ? et : (i < 8) ? eo : 7'h00;
      ed = (i < 4 || i == 12);
      er = (i >= 8 && i < 12);
      total++;
      if (seg_o !== es || dp_o !== ed || result_ready_o !== er ||
          busy_o !== 1'b1) begin
        bad++;
        $display("FAIL %s cyc%0d seg=%h dp=%b rdy=%b busy=%b want %h %b %b 1",
                 nm, i, seg_o, dp_o, result_ready_o, busy_o, es, ed, er);
      end
      step();
    end
  endtask

  task automatic test_decimal();
    test_value(6'd42, E42_T, E42_O, "val42");
    test_value(6'd63, E63_T, E63_O, "val63");
    test_value(6'd0, 7'h3F, 7'h3F, "val0");
  endtask

  task automatic test_ignore_busy();
    logic [6:0] es;
    do_reset();
    result_i = 6'd42;
    result_valid_i = 1'b1;
    step();
    result_i = 6'd17;
    for (int i = 0; i < 9; i++) begin
      es = (i < 4) ? E42_T : (i < 8) ? E42_O : 7'h00;
      total++;
      if (seg_o !== es || result_ready_o !== (i == 8)) begin
        bad++;
        $display("FAIL ignore cyc%0d seg=%h rdy=%b want %h %b",
                 i, seg_o, result_ready_o, es, (i == 8));
      end
      if (i < 8) step();
    end
    step();
    result_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      es = (i < 4) ? 7'h06 : E17_O;
      total++;
      if (seg_o !== es || dp_o !== (i < 4) || result_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL accept17 cyc%0d seg=%h dp=%b rdy=%b want %h %b 0",
                 i, seg_o, dp_o, result_ready_o, es, (i < 4));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    result_i = 6'd42;
    result_valid_i = 1'b1;
    step();
    result_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (seg_o !== E42_O || dp_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre seg=%h dp=%b want %h 0", seg_o, dp_o, E42_O);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      total++;
      if (seg_o !== 7'h00 || dp_o !== 1'b0 ||
          busy_o !== 1'b0 || result_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL mid_rst cyc%0d seg=%h dp=%b busy=%b rdy=%b want 00 0 0 1",
                 i, seg_o, dp_o, busy_o, result_ready_o);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_ignore_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
